// File: rtl/lsu_agu_arb.sv
// Shared LSU address adder: round-robin load/store arbitration, addr = base + offset (LSU_AGU_MISALIGN_CHK_EN adds misalign flag).
// Latency: 1 cycle from accept to out_valid_o; throughput 1 address/cycle.
// Backpressure: output register holds while out_valid_o & !out_ready_i; both readys drop until it drains.
module lsu_agu_arb #(
   parameter int XLEN             = 64,
   parameter int VIRTUAL_ADDR_LEN = 39,
   parameter int TAG_W            = 5
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        flush_i,
   input  logic                        ld_valid_i,
   output logic                        ld_ready_o,
   input  logic [XLEN-1:0]             ld_base_i,
   input  logic [XLEN-1:0]             ld_offset_i,
   input  logic [TAG_W-1:0]            ld_tag_i,
   input  logic [1:0]                  ld_size_i,
   input  logic                        st_valid_i,
   output logic                        st_ready_o,
   input  logic [XLEN-1:0]             st_base_i,
   input  logic [XLEN-1:0]             st_offset_i,
   input  logic [TAG_W-1:0]            st_tag_i,
   input  logic [1:0]                  st_size_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [VIRTUAL_ADDR_LEN-1:0] out_addr_o,
   output logic [TAG_W-1:0]            out_tag_o,
   output logic [1:0]                  out_size_o,
   output logic                        out_is_store_o,
   output logic                        out_misalign_o
);

   localparam int VA = VIRTUAL_ADDR_LEN;

   typedef struct packed {
      logic [VA-1:0]    addr;
      logic [TAG_W-1:0] tag;
      logic [1:0]       size;
      logic             is_store;
   } res_t;

   logic          rr_last;      // 1 = store was granted last
   logic          out_valid;
   logic          can_accept;
   logic          grant_ld;
   logic          grant_st;
   logic          accept;
   logic [VA-1:0] sel_base;
   logic [VA-1:0] sel_off;
   res_t          res_d;
   res_t          res_q;

   // Upper operand bits never reach the virtual address.
   logic unused_upper;
   assign unused_upper = ^{ld_base_i[XLEN-1:VA], ld_offset_i[XLEN-1:VA],
                           st_base_i[XLEN-1:VA], st_offset_i[XLEN-1:VA]};

   assign can_accept = ~flush_i & (~out_valid | out_ready_i);
   assign grant_ld   = ld_valid_i & (~st_valid_i | rr_last);
   assign grant_st   = st_valid_i & (~ld_valid_i | ~rr_last);
   assign ld_ready_o = can_accept & grant_ld;
   assign st_ready_o = can_accept & grant_st;
   assign accept     = ld_ready_o | st_ready_o;

   always_comb begin
      sel_base       = grant_st ? st_base_i[VA-1:0]   : ld_base_i[VA-1:0];
      sel_off        = grant_st ? st_offset_i[VA-1:0] : ld_offset_i[VA-1:0];
      res_d          = '0;
      res_d.addr     = sel_base + sel_off;
      res_d.tag      = grant_st ? st_tag_i  : ld_tag_i;
      res_d.size     = grant_st ? st_size_i : ld_size_i;
      res_d.is_store = grant_st;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         res_q     <= '0;
         rr_last   <= 1'b1;
      end else if (flush_i) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         res_q     <= res_d;
         rr_last   <= grant_st;
      end else if (out_ready_i) begin
         out_valid <= 1'b0;
      end
   end

`ifdef LSU_AGU_MISALIGN_CHK_EN
   logic mis_d;
   logic mis_q;

   always_comb begin
      mis_d = 1'b0;
      case (res_d.size)
         2'd1:    mis_d = res_d.addr[0];
         2'd2:    mis_d = |res_d.addr[1:0];
         2'd3:    mis_d = |res_d.addr[2:0];
         default: mis_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         mis_q <= 1'b0;
      else if (!flush_i && accept)
         mis_q <= mis_d;
   end

   assign out_misalign_o = mis_q;
`else
   assign out_misalign_o = 1'b0;
`endif

   assign out_valid_o    = out_valid;
   assign out_addr_o     = res_q.addr;
   assign out_tag_o      = res_q.tag;
   assign out_size_o     = res_q.size;
   assign out_is_store_o = res_q.is_store;

endmodule
